// File: rtl/wb_slave_mem_responder.sv
// Wishbone classic slave responder with word memory, byte-lane writes and wait states.
// Optional retry terminations are enabled by defining WB_RESP_RTY_EN.
module wb_slave_mem_responder #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int                    MEM_DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
    parameter int                    RTY_PERIOD     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   wbs_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    input  logic                    wbs_we_i,
    input  logic [SELECT_WIDTH-1:0] wbs_sel_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    output logic                    wbs_ack_o,
    output logic                    wbs_err_o,
    output logic                    wbs_rty_o,
    input  logic [3:0]              wait_cycles_i,
    output logic [15:0]             access_cnt_o
);

    localparam int LANE_LSB  = $clog2(SELECT_WIDTH);
    localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(SELECT_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   adr_r;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic [SELECT_WIDTH-1:0] sel_r;
    logic                    we_r;
    logic [3:0]              wait_cnt_r;
    logic [DATA_WIDTH-1:0]   mem_r [0:MEM_DEPTH-1];

    logic                      req_s;
    logic [ADDR_WIDTH-1:0]     cur_adr_s;
    logic [DATA_WIDTH-1:0]     cur_dat_s;
    logic [SELECT_WIDTH-1:0]   cur_sel_s;
    logic                      cur_we_s;
    logic [ADDR_WIDTH-1:0]     off_s;
    logic [ADDR_WIDTH-1:0]     shifted_s;
    logic [MEM_DEPTH_LOG2-1:0] idx_s;
    logic                      dec_err_s;
    logic                      enter_resp_s;
    logic                      rty_hit_s;
    logic                      wr_en_s;

`ifdef WB_RESP_RTY_EN
    localparam int RTY_CNT_W = $clog2(RTY_PERIOD);
    logic [RTY_CNT_W-1:0] rty_cnt_r;
`endif

    // Request decode: in IDLE the live bus is used so a zero-wait access completes at accept.
    always_comb begin
        req_s = wbs_cyc_i & wbs_stb_i;
        if (state_r == ST_IDLE) begin
            cur_adr_s = wbs_adr_i;
            cur_dat_s = wbs_dat_i;
            cur_sel_s = wbs_sel_i;
            cur_we_s  = wbs_we_i;
        end else begin
            cur_adr_s = adr_r;
            cur_dat_s = dat_r;
            cur_sel_s = sel_r;
            cur_we_s  = we_r;
        end
        off_s     = cur_adr_s - BASE_ADDR;
        shifted_s = off_s >> LANE_LSB;
        idx_s     = shifted_s[MEM_DEPTH_LOG2-1:0];
        dec_err_s = (cur_adr_s < BASE_ADDR)
                 || (shifted_s[ADDR_WIDTH-1:MEM_DEPTH_LOG2] != {(ADDR_WIDTH-MEM_DEPTH_LOG2){1'b0}})
                 || ((off_s & ALIGN_MASK) != {ADDR_WIDTH{1'b0}});
        case (state_r)
            ST_IDLE: enter_resp_s = req_s && (wait_cycles_i == 4'd0);
            ST_WAIT: enter_resp_s = req_s && (wait_cnt_r == 4'd0);
            default: enter_resp_s = 1'b0;
        endcase
`ifdef WB_RESP_RTY_EN
        rty_hit_s = !dec_err_s && (rty_cnt_r == RTY_CNT_W'(RTY_PERIOD - 1));
`else
        rty_hit_s = 1'b0;
`endif
        wr_en_s = enter_resp_s && !dec_err_s && !rty_hit_s && cur_we_s;
    end

    // Memory array: byte-lane writes, never cleared by reset.
    always_ff @(posedge clk) begin
        if (rst && wr_en_s) begin
            for (int i = 0; i < SELECT_WIDTH; i++) begin
                if (cur_sel_s[i]) begin
                    mem_r[idx_s][i*8 +: 8] <= cur_dat_s[i*8 +: 8];
                end
            end
        end
    end

    // Control FSM with registered one-cycle terminations and access counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            adr_r        <= {ADDR_WIDTH{1'b0}};
            dat_r        <= {DATA_WIDTH{1'b0}};
            sel_r        <= {SELECT_WIDTH{1'b0}};
            we_r         <= 1'b0;
            wait_cnt_r   <= 4'd0;
            wbs_dat_o    <= {DATA_WIDTH{1'b0}};
            wbs_ack_o    <= 1'b0;
            wbs_err_o    <= 1'b0;
            access_cnt_o <= 16'd0;
`ifdef WB_RESP_RTY_EN
            wbs_rty_o    <= 1'b0;
            rty_cnt_r    <= {RTY_CNT_W{1'b0}};
`endif
        end else begin
            wbs_dat_o <= {DATA_WIDTH{1'b0}};
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
`ifdef WB_RESP_RTY_EN
            wbs_rty_o <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        adr_r <= wbs_adr_i;
                        dat_r <= wbs_dat_i;
                        sel_r <= wbs_sel_i;
                        we_r  <= wbs_we_i;
                        if (wait_cycles_i == 4'd0) begin
                            state_r <= ST_RESP;
                        end else begin
                            state_r    <= ST_WAIT;
                            wait_cnt_r <= wait_cycles_i - 4'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req_s) begin
                        state_r <= ST_IDLE;
                    end else if (wait_cnt_r == 4'd0) begin
                        state_r <= ST_RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ST_RESP: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
            if (enter_resp_s) begin
                access_cnt_o <= access_cnt_o + 16'd1;
                if (dec_err_s) begin
                    wbs_err_o <= 1'b1;
                end else if (rty_hit_s) begin
`ifdef WB_RESP_RTY_EN
                    wbs_rty_o <= 1'b1;
`endif
                end else begin
                    wbs_ack_o <= 1'b1;
                    if (!cur_we_s) begin
                        wbs_dat_o <= mem_r[idx_s];
                    end
                end
`ifdef WB_RESP_RTY_EN
                if (!dec_err_s) begin
                    rty_cnt_r <= rty_hit_s ? {RTY_CNT_W{1'b0}} : rty_cnt_r + {{(RTY_CNT_W-1){1'b0}}, 1'b1};
                end
`endif
            end
        end
    end

`ifndef WB_RESP_RTY_EN
    assign wbs_rty_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_slave_mem_responder.sv
// Scoreboard bench for wb_slave_mem_responder: random and directed accesses against a word-array model.
module tb_wb_slave_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] adr = 32'd0;
    logic [31:0] dat_i = 32'd0;
    logic [31:0] dat_o;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        ack, err, rty;
    logic [3:0]  wt = 4'd0;
    logic [15:0] acc;

    wb_slave_mem_responder dut (
        .clk(clk), .rst(rst),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_ack_o(ack), .wbs_err_o(err), .wbs_rty_o(rty),
        .wait_cycles_i(wt), .access_cnt_o(acc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 ack, 1 err, 2 rty
        logic [31:0] data;
        int          when;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mem_m [0:1023];
    int          retry_m = 0;
    logic [15:0] acc_m = 16'd0;
    int          cycle = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    // Reference rules: build the expected termination for one request.
    function automatic exp_t predict(input logic [31:0] a, input logic w, input logic [3:0] s,
                                     input logic [31:0] d, input int wait_n);
        exp_t e;
        int   idx;
        idx = int'(a >> 2);
        e.data = 32'd0;
        if (a[1:0] != 2'd0 || a >= 32'h0000_1000) begin
            e.kind = 1;
        end else begin
            retry_m++;
`ifdef WB_RESP_RTY_EN
            if (retry_m == 4) begin
                e.kind  = 2;
                retry_m = 0;
            end else
`endif
            begin
                e.kind = 0;
                if (w) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mem_m[idx][b*8 +: 8] = d[b*8 +: 8];
                end else begin
                    e.data = mem_m[idx];
                end
            end
        end
        acc_m  = acc_m + 16'd1;
        e.cnt  = acc_m;
        e.when = cycle + 1 + wait_n;
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d, input logic [3:0] wn);
        bit got;
        @(negedge clk);
        adr = a; we = w; sel = s; dat_i = d; wt = wn; cyc = 1'b1; stb = 1'b1;
        exp_q.push_back(predict(a, w, s, d, int'(wn)));
        @(negedge clk);
        wt = 4'($urandom_range(0, 15));
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (ack | err | rty) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        cyc = 1'b0; stb = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL timeout adr=%h no termination within 40 cycles", a);
        end
    endtask

    // Monitor: every termination must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            if (ack | err | rty) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_term ack=%b err=%b rty=%b", ack, err, rty);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("onehot", 32'($countones({ack, err, rty})), 32'd1);
                    check("kind", {29'd0, rty, err, ack},
                          (mon_e.kind == 0) ? 32'd1 : (mon_e.kind == 1) ? 32'd2 : 32'd4);
                    check("dat_o", dat_o, mon_e.data);
                    check("latency", 32'(cycle), 32'(mon_e.when));
                    check("access_cnt", {16'd0, acc}, {16'd0, mon_e.cnt});
                end
            end else begin
                check("dat_idle", dat_o, 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] a;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rty", {31'd0, rty}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_cnt", {16'd0, acc}, 32'd0);
        rst = 1'b1;

        // Basic write/read with zero wait.
        issue(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 4'd0);
        issue(32'h10, 1'b0, 4'h0, 32'h0, 4'd0);
        @(negedge clk);
        check("cnt_after_two", {16'd0, acc}, 32'd2);

        // Preload 16 words, then byte lane merge.
        for (int i = 0; i < 16; i++) issue(32'(i * 4), 1'b1, 4'hF, $urandom, 4'd0);
        issue(32'h20, 1'b1, 4'hF, 32'h11223344, 4'd0);
        issue(32'h20, 1'b1, 4'h5, 32'hAABBCCDD, 4'd1);
        issue(32'h20, 1'b0, 4'h0, 32'h0, 4'd0);
        issue(32'h24, 1'b1, 4'h0, 32'hFFFFFFFF, 4'd2);
        issue(32'h24, 1'b0, 4'h3, 32'h0, 4'd3);

        // Error decode: misaligned and out of range, memory untouched.
        issue(32'h1002, 1'b1, 4'hF, 32'h12345678, 4'd0);
        issue(32'h1000, 1'b1, 4'hF, 32'h12345678, 4'd2);
        issue(32'h0012, 1'b1, 4'hF, 32'h0BADF00D, 4'd0);
        issue(32'h10, 1'b0, 4'hF, 32'h0, 4'd0);

        // Abort mid-wait: no write, no termination, count unchanged.
        @(negedge clk);
        adr = 32'h10; we = 1'b1; sel = 4'hF; dat_i = 32'h55555555; wt = 4'd5;
        cyc = 1'b1; stb = 1'b1;
        repeat (2) @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        cyc = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_cnt", {16'd0, acc}, {16'd0, acc_m});
        issue(32'h10, 1'b0, 4'hF, 32'h0, 4'd0);

        // Randomized traffic, mostly in the preloaded 16-word window.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                1:       a = 32'h1000 + 32'($urandom_range(0, 4095) * 4);
                default: a = 32'($urandom_range(0, 15) * 4);
            endcase
            issue(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, 4'($urandom_range(0, 4)));
        end

        // Reset during WAIT: outputs clear at once, memory keeps data.
        @(negedge clk);
        adr = 32'h8; we = 1'b0; sel = 4'hF; wt = 4'd5; cyc = 1'b1; stb = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_cnt", {16'd0, acc}, 32'd0);
        check("midrst_ack", {29'd0, ack, err, rty}, 32'd0);
        check("midrst_dat", dat_o, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        acc_m   = 16'd0;
        retry_m = 0;
        @(negedge clk);
        rst = 1'b1;

        // Eight in-range reads; with retry enabled the 4th and 8th retry.
        for (int i = 0; i < 8; i++) issue(32'(i * 4), 1'b0, 4'hF, 32'h0, 4'd0);
        @(negedge clk);
        check("cnt_eight", {16'd0, acc}, 32'd8);
        for (int i = 0; i < 16; i++) issue(32'(i * 4), 1'b0, 4'h0, 32'h0, 4'($urandom_range(0, 2)));

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_slave_mem_responder.md
Name: wb_slave_mem_responder

Overview:
- Wishbone classic (B4 non-pipelined) slave responder and memory model for the AXI-to-Wishbone bench.
- Terminates the master-side Wishbone signals driven by the bridge under test.
- Returns ack, err or rty with programmable wait states, and keeps word-addressed memory with byte-lane writes.
- Used as the far-end target for scoreboard checks.

Parameters:
- ADDR_WIDTH, 32, address bus width in bits.
- DATA_WIDTH, 32, data bus width in bits (8/16/32/64).
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width.
- MEM_DEPTH_LOG2, 10, log2 of the memory depth in words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- RTY_PERIOD, 4, every Nth accepted request is answered with rty. Only used with the optional feature. Must be at least 2.

Ports:
- clk  in  1  bench clock; all state on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wbs_adr_i  in  ADDR_WIDTH  byte address.
- wbs_dat_i  in  DATA_WIDTH  write data.
- wbs_dat_o  out  DATA_WIDTH  read data.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_sel_i  in  SELECT_WIDTH  byte lane enables.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_ack_o  out  1  normal termination.
- wbs_err_o  out  1  error termination.
- wbs_rty_o  out  1  retry termination.
- wait_cycles_i  in  4  wait states inserted per access, sampled at request accept.
- access_cnt_o  out  16  count of completed terminations (ack, err or rty). Wraps from 0xFFFF to 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o and access_cnt_o all 0.
  - Internal wait counter and retry counter 0.
  - Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Accept occurs at the rising edge where wbs_cyc_i & wbs_stb_i = 1.
  - At accept, latch adr, we, sel, dat_i and wait_cycles_i.
  - If the latched wait is 0, go to RESP; otherwise go to WAIT with the counter loaded with wait_cycles_i - 1.
- WAIT:
  - Decrement the counter each cycle; go to RESP on the cycle the counter reads 0.
  - Abort: if wbs_cyc_i = 0 or wbs_stb_i = 0 at any edge in WAIT, return to IDLE. No memory write, no termination, no count.
- Termination is registered:
  - Exactly one of ack/err/rty is high for exactly one cycle while in RESP.
  - Request accepted at edge T ⇒ termination visible in cycle T+1+wait.
  - RESP always returns to IDLE, so back-to-back requests have one idle cycle between terminations.
  - access_cnt_o increments on entry to RESP.
- Address decode:
  - offset = adr - BASE_ADDR; word index = offset >> log2(SELECT_WIDTH).
  - err when any of: adr < BASE_ADDR; word index >= 2^MEM_DEPTH_LOG2; low log2(SELECT_WIDTH) offset bits nonzero (misaligned).
  - On err: no write, wbs_dat_o = 0.
- Write (we=1, ack path):
  - Memory updated at the edge entering RESP.
  - Only lanes with sel=1 are written; sel=0 still acks with no change.
- Read (we=0, ack path):
  - wbs_dat_o = full word at that index regardless of sel, valid only in the ack cycle. It is 0 in all other cycles.
- wbs_err_o and wbs_rty_o are never high together with wbs_ack_o.

Optional Feature:
- Macro: WB_RESP_RTY_EN.
- Defined:
  - A retry counter counts accepted requests that decode in range.
  - Every RTY_PERIOD-th such request terminates with wbs_rty_o instead of ack, with no write and wbs_dat_o = 0. The counter then resets to 0.
  - Aborted and err requests do not advance the counter.
- Not defined:
  - wbs_rty_o is tied to 0 and no retry counter logic exists.

Test Plan:
- Reset then write/read: wait=0; write adr 0x10, dat 0xDEADBEEF, sel 0xF ⇒ ack one cycle at T+1. Read adr 0x10 ⇒ ack with dat_o 0xDEADBEEF; access_cnt_o = 2.
- Byte lanes: word 0x20 preloaded 0x11223344; write dat 0xAABBCCDD, sel 0x5 ⇒ read returns 0x11BB33DD.
- Wait states: wait_cycles_i = 3; read ⇒ ack exactly at T+4. Changing wait_cycles_i to 0 during WAIT does not shorten the access.
- Errors: adr 0x1002 (misaligned) ⇒ err, no ack. adr 0x1000 with MEM_DEPTH_LOG2 = 10 (word 1024, out of range) ⇒ err. Memory unchanged in both cases.
- Abort/reset:
  - wait = 5; drop wbs_stb_i after 2 cycles ⇒ no termination, no write, count unchanged.
  - Assert rst low mid-WAIT ⇒ outputs 0 immediately, memory retains data.
- WB_RESP_RTY_EN with RTY_PERIOD = 4: 8 in-range reads ⇒ rty on the 4th and 8th, ack on the others; access_cnt_o = 8.
